ahb_sram_bridge: RTL and testbench
==================================

Name: ahb_sram_bridge

Overview:
AHB-Lite slave that converts bus transfers into the single-port, byte-enabled, one-cycle-read-latency SRAM port (ADDR/WDATA/WREN/CS in, RDATA out).
- Sits directly upstream of the word-wide program/data SRAM on the Cortex-M0 bus matrix.
- Writes are posted into a one-entry write buffer and drained when the SRAM port is free.
- Reads that hit the buffer are merged byte-wise. A read colliding with a buffer refill takes one wait state.

Parameters:
AW, 14, SRAM word-address width. Byte address on the bus is AW+2 bits.

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
HSEL  input  1  slave select
HREADY  input  1  bus ready (previous transfer completing)
HTRANS  input  2  transfer type; bit1=1 means NONSEQ/SEQ
HSIZE  input  3  0=byte, 1=half, 2=word; values >2 treated as word
HWRITE  input  1  1=write
HADDR  input  AW+2  byte address
HWDATA  input  32  write data (data phase)
HREADYOUT  output  1  slave ready
HRESP  output  1  always 0 (OKAY)
HRDATA  output  32  read data (data phase)
SRAMADDR  output  AW  word address to SRAM
SRAMWDATA  output  32  write data to SRAM
SRAMWEN  output  4  byte write enables
SRAMCS  output  1  SRAM chip select
SRAMRDATA  input  32  SRAM read data, valid the cycle after a read issue

Behaviour:
Clock, reset and reset values
- One clock: CLK. RST is synchronous and active-high.
- On reset: HREADYOUT=1 and HRDATA=0. All write-buffer, data-phase and pending state is cleared; any posted write is discarded.
- Combinational outputs are also idle during and after reset: SRAMWEN=0, SRAMCS=0.

Transfer acceptance and byte lanes
- A transfer is accepted when HSEL & HREADY & HTRANS[1].
- rd_acc = accepted & ~HWRITE; wr_acc = accepted & HWRITE.
- Byte mask decode:
  - byte: one lane, selected by HADDR[1:0].
  - half: HADDR[1]=0 gives 4'b0011; HADDR[1]=1 gives 4'b1100.
  - word: 4'b1111.
  - HADDR[0] is ignored for halfwords; HADDR[1:0] is ignored for words.

Write path
- wr_acc registers dp_wr=1, dp_addr=HADDR[AW+1:2] and dp_mask.
- At the end of a cycle with dp_wr=1 and HREADYOUT=1, the buffer is loaded: buf_addr<=dp_addr, buf_mask<=dp_mask, buf_data<=HWDATA, buf_full<=1.
- Drain: buf_full=1 & ~rd_acc & ~rd_pend, in that cycle drive:
  - SRAMCS=1, SRAMWEN=buf_mask, SRAMADDR=buf_addr, SRAMWDATA=buf_data.
  - buf_full clears at the end of the cycle unless the buffer is reloaded on the same edge; reload wins.

Read path
- rd_acc with no conflict: SRAMCS=1, SRAMWEN=0, SRAMADDR=HADDR[AW+1:2] in the same cycle.
  - rdp_addr is registered; data returns next cycle with zero wait states.
- Conflict: rd_acc & buf_full & buffer reload due this cycle.
  - This cycle drains the old buffer instead; the read is not issued.
  - rd_pend<=1, rdp_addr captured.
- Next cycle (rd_pend=1): HREADYOUT=0, SRAM read of rdp_addr issued, no drain. rd_pend then clears.
- The following cycle has HREADYOUT=1 and HRDATA valid.

Read data merge
- In the data-return cycle, hit = buf_full & (buf_addr==rdp_addr), evaluated on current buffer state.
- HRDATA lane i = (hit & buf_mask[i]) ? buf_data lane i : SRAMRDATA lane i.
- Outside read data-return cycles HRDATA=0.

Ordering and exclusivity
- Only one of drain or read is ever issued per cycle.
- No write is lost; SRAM write order equals bus order.
- Idle, busy and unselected cycles still allow a drain.

Test Plan:
1. Word write HADDR=0x0010, HWDATA=0xDEADBEEF, then IDLE -> one cycle after the data phase: SRAMCS=1, SRAMWEN=4'hF, SRAMADDR=4, SRAMWDATA=0xDEADBEEF. HREADYOUT stays 1.
2. Word write 0x20 = 0x12345678, immediately followed by a word read of 0x20 (SRAM holds 0) -> HRDATA=0x12345678 with zero wait states (merge hit). Drain follows in the next idle cycle.
3. Byte write HADDR=0x0003, HWDATA=0xAA000000 -> SRAMWEN=4'b1000. Halfword write HADDR=0x0006 -> SRAMWEN=4'b1100. Byte read of 0x3 after a byte write of 0x3, SRAM word 0x11223344 -> HRDATA=0xAA223344.
4. Back-to-back write Z (0x40) = 0x1, write A (0x44) = 0x2, read B (0x48), SRAM[B]=0x55 -> in the B address cycle SRAM writes Z. The B data phase has HREADYOUT=0 for exactly one cycle with a SRAM read of word 0x12. HRDATA=0x55 on the next cycle. A is drained afterwards.
5. Write to 0x80 with RST asserted in the cycle after its data phase -> no SRAM write ever occurs. After reset HREADYOUT=1, SRAMWEN=0, and a read of 0x80 returns old SRAM contents.
6. HSEL=0 or HTRANS=IDLE with pending buffer -> drain occurs. HTRANS=BUSY with HSEL=1 -> no read/write accepted; HRESP stays 0 throughout.

Source files
------------

// File: rtl/ahb_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_bridge
// Brief    : AHB-Lite slave to single-port byte-enabled SRAM, with a one-entry
//            posted write buffer and byte-wise read merge from that buffer.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_sram_bridge #(
    parameter int AW = 14
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          HSEL,
    input  logic          HREADY,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [AW+1:0] HADDR,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic [AW-1:0] SRAMADDR,
    output logic [31:0]   SRAMWDATA,
    output logic [3:0]    SRAMWEN,
    output logic          SRAMCS,
    input  logic [31:0]   SRAMRDATA
);

    logic          w_accept;
    logic          w_rd_acc;
    logic          w_wr_acc;
    logic          w_load;
    logic          w_conflict;
    logic          w_drain;
    logic          w_rd_issue;
    logic          w_hit;
    logic [3:0]    w_mask;
    logic          w_unused;

    logic          r_dp_wr;
    logic [AW-1:0] r_dp_addr;
    logic [3:0]    r_dp_mask;
    logic          r_buf_full;
    logic [AW-1:0] r_buf_addr;
    logic [3:0]    r_buf_mask;
    logic [31:0]   r_buf_data;
    logic          r_rd_pend;
    logic          r_rd_ret;
    logic [AW-1:0] r_rdp_addr;

    // NONSEQ and SEQ are handled identically, so HTRANS[0] carries no information
    assign w_unused = HTRANS[0];

    assign w_accept = HSEL & HREADY & HTRANS[1];
    assign w_rd_acc = w_accept & ~HWRITE;
    assign w_wr_acc = w_accept & HWRITE;

    always_comb begin
        w_mask = 4'b1111;
        case (HSIZE)
            3'd0:    w_mask = 4'b0001 << HADDR[1:0];
            3'd1:    w_mask = HADDR[1] ? 4'b1100 : 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    assign HREADYOUT = ~r_rd_pend;
    assign HRESP     = 1'b0;

    // A read arriving while the buffer is both occupied and about to be refilled
    // lets the old entry drain first and replays the read one cycle later.
    assign w_load     = r_dp_wr & HREADYOUT;
    assign w_conflict = w_rd_acc & r_buf_full & w_load;
    assign w_drain    = r_buf_full & ~r_rd_pend & (~w_rd_acc | w_conflict);
    assign w_rd_issue = (w_rd_acc & ~w_conflict) | r_rd_pend;

    always_comb begin
        SRAMCS    = 1'b0;
        SRAMWEN   = 4'b0000;
        SRAMADDR  = HADDR[AW+1:2];
        SRAMWDATA = r_buf_data;
        if (!RST) begin
            if (w_drain) begin
                SRAMCS   = 1'b1;
                SRAMWEN  = r_buf_mask;
                SRAMADDR = r_buf_addr;
            end else if (w_rd_issue) begin
                SRAMCS   = 1'b1;
                SRAMADDR = r_rd_pend ? r_rdp_addr : HADDR[AW+1:2];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dp_wr    <= 1'b0;
            r_dp_addr  <= '0;
            r_dp_mask  <= 4'b0000;
            r_buf_full <= 1'b0;
            r_buf_addr <= '0;
            r_buf_mask <= 4'b0000;
            r_buf_data <= 32'h0000_0000;
            r_rd_pend  <= 1'b0;
            r_rd_ret   <= 1'b0;
            r_rdp_addr <= '0;
        end else begin
            if (HREADY) begin
                r_dp_wr <= w_wr_acc;
                if (w_wr_acc) begin
                    r_dp_addr <= HADDR[AW+1:2];
                    r_dp_mask <= w_mask;
                end
            end
            // Reload takes priority over the drain clearing the entry
            if (w_load) begin
                r_buf_full <= 1'b1;
                r_buf_addr <= r_dp_addr;
                r_buf_mask <= r_dp_mask;
                r_buf_data <= HWDATA;
            end else if (w_drain) begin
                r_buf_full <= 1'b0;
            end
            if (w_rd_acc) begin
                r_rdp_addr <= HADDR[AW+1:2];
            end
            r_rd_pend <= w_conflict;
            r_rd_ret  <= (w_rd_acc & ~w_conflict) | r_rd_pend;
        end
    end

    assign w_hit = r_buf_full & (r_buf_addr == r_rdp_addr);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign HRDATA[8*gi +: 8] = !r_rd_ret ? 8'h00 :
                                   (w_hit & r_buf_mask[gi]) ? r_buf_data[8*gi +: 8] :
                                   SRAMRDATA[8*gi +: 8];
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_sram_bridge
// Brief    : Self-checking bench: directed scenarios plus randomized traffic
//            checked against a flat word-memory reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_bridge;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hsel;
    logic          hready;
    logic [1:0]    htrans;
    logic [2:0]    hsize;
    logic          hwrite;
    logic [AW+1:0] haddr;
    logic [31:0]   hwdata;
    logic          hreadyout;
    logic          hresp;
    logic [31:0]   hrdata;
    logic [AW-1:0] sramaddr;
    logic [31:0]   sramwdata;
    logic [3:0]    sramwen;
    logic          sramcs;
    logic [31:0]   sramrdata = 32'h0;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] sram    [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:7];

    always #5 clk = ~clk;

    // Single-slave system: the bus ready is this slave's own ready
    assign hready = hreadyout;

    ahb_sram_bridge #(.AW(AW)) dut (
        .CLK(clk), .RST(rst), .HSEL(hsel), .HREADY(hready), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata),
        .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata),
        .SRAMADDR(sramaddr), .SRAMWDATA(sramwdata), .SRAMWEN(sramwen),
        .SRAMCS(sramcs), .SRAMRDATA(sramrdata)
    );

    always @(posedge clk) begin
        if (sramcs) begin
            if (sramwen == 4'b0000) begin
                sramrdata <= sram[sramaddr];
            end else begin
                for (int l = 0; l < 4; l++)
                    if (sramwen[l]) sram[sramaddr][8*l +: 8] <= sramwdata[8*l +: 8];
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (hresp !== 1'b0) begin
            miscompares++;
            $display("FAIL hresp: got %b expected 0 at %0t", hresp, $time);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] lane_mask(input logic [2:0] z, input logic [1:0] a);
        case (z)
            3'd0:    return 4'b0001 << a;
            3'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [1:0] t, input logic w,
                         input logic [2:0] z, input logic [15:0] a);
        hsel = s; htrans = t; hwrite = w; hsize = z; haddr = a;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 1'b0, 3'd0, 16'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        @(negedge clk);
        vectors++;
        if ({sramcs, sramwen} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_sram_idle: got cs=%b wen=%h expected cs=0 wen=0", sramcs, sramwen);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({hreadyout, hrdata, sramcs, sramwen} !== {1'b1, 32'h0, 1'b0, 4'h0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got ready=%b rdata=%h cs=%b wen=%h expected 1/0/0/0",
                     hreadyout, hrdata, sramcs, sramwen);
        end
        step();
    endtask

    task automatic test_word_write();
        drive(1'b1, 2'b10, 1'b1, 3'd2, 16'h0010);
        step();
        idle();
        hwdata = 32'hDEADBEEF;
        @(negedge clk);
        vectors++;
        if (sramcs !== 1'b0) begin
            miscompares++;
            $display("FAIL ww_no_early_write: got cs=%b expected 0", sramcs);
        end
        step();
        @(negedge clk);
        vectors++;
        if ({sramcs, sramwen, sramaddr, sramwdata} !== {1'b1, 4'hF, 14'd4, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL ww_drain: got cs=%b wen=%h addr=%h wdata=%h expected 1/f/0004/deadbeef",
                     sramcs, sramwen, sramaddr, sramwdata);
        end
        vectors++;
        if (hreadyout !== 1'b1) begin
            miscompares++;
            $display("FAIL ww_ready: got %b expected 1", hreadyout);
        end
        step();
    endtask

    task automatic test_merge_hit();
        sram[8] = 32'h0;
        drive(1'b1, 2'b10, 1'b1, 3'd2, 16'h0020);
        step();
        hwdata = 32'h12345678;
        drive(1'b1, 2'b10, 1'b0, 3'd2, 16'h0020);
        @(negedge clk);
        vectors++;
        if ({sramcs, sramwen, sramaddr} !== {1'b1, 4'h0, 14'd8}) begin
            miscompares++;
            $display("FAIL mh_read_issue: got cs=%b wen=%h addr=%h expected 1/0/0008", sramcs, sramwen, sramaddr);
        end
        step();
        idle();
        @(negedge clk);
        vectors++;
        if ({hreadyout, hrdata} !== {1'b1, 32'h12345678}) begin
            miscompares++;
            $display("FAIL mh_rdata: got ready=%b rdata=%h expected 1/12345678", hreadyout, hrdata);
        end
        vectors++;
        if ({sramcs, sramwen, sramaddr} !== {1'b1, 4'hF, 14'd8}) begin
            miscompares++;
            $display("FAIL mh_drain: got cs=%b wen=%h addr=%h expected 1/f/0008", sramcs, sramwen, sramaddr);
        end
        step();
    endtask

    task automatic test_byte_lanes();
        drive(1'b1, 2'b10, 1'b1, 3'd0, 16'h0003);
        step();
        idle();
        hwdata = 32'hAA000000;
        step();
        @(negedge clk);
        vectors++;
        if ({sramcs, sramwen, sramaddr} !== {1'b1, 4'b1000, 14'd0}) begin
            miscompares++;
            $display("FAIL bl_byte_wen: got cs=%b wen=%b addr=%h expected 1/1000/0000", sramcs, sramwen, sramaddr);
        end
        step();
        drive(1'b1, 2'b10, 1'b1, 3'd1, 16'h0006);
        step();
        idle();
        hwdata = 32'hBEEF0000;
        step();
        @(negedge clk);
        vectors++;
        if ({sramcs, sramwen, sramaddr} !== {1'b1, 4'b1100, 14'd1}) begin
            miscompares++;
            $display("FAIL bl_half_wen: got cs=%b wen=%b addr=%h expected 1/1100/0001", sramcs, sramwen, sramaddr);
        end
        step();
        sram[0] = 32'h11223344;
        drive(1'b1, 2'b10, 1'b1, 3'd0, 16'h0003);
        step();
        hwdata = 32'hAA000000;
        drive(1'b1, 2'b10, 1'b0, 3'd0, 16'h0003);
        step();
        idle();
        @(negedge clk);
        vectors++;
        if (hrdata !== 32'hAA223344) begin
            miscompares++;
            $display("FAIL bl_byte_merge: got %h expected aa223344", hrdata);
        end
        step();
        step();
    endtask

    task automatic test_back_to_back();
        sram[18] = 32'h00000055;
        drive(1'b1, 2'b10, 1'b1, 3'd2, 16'h0040);
        step();
        hwdata = 32'h1;
        drive(1'b1, 2'b10, 1'b1, 3'd2, 16'h0044);
        step();
        hwdata = 32'h2;
        drive(1'b1, 2'b10, 1'b0, 3'd2, 16'h0048);
        @(negedge clk);
        vectors++;
        if ({sramcs, sramwen, sramaddr, sramwdata} !== {1'b1, 4'hF, 14'h10, 32'h1}) begin
            miscompares++;
            $display("FAIL b2b_drain_z: got cs=%b wen=%h addr=%h wdata=%h expected 1/f/0010/00000001",
                     sramcs, sramwen, sramaddr, sramwdata);
        end
        step();
        idle();
        @(negedge clk);
        vectors++;
        if ({hreadyout, sramcs, sramwen, sramaddr} !== {1'b0, 1'b1, 4'h0, 14'h12}) begin
            miscompares++;
            $display("FAIL b2b_wait_read: got ready=%b cs=%b wen=%h addr=%h expected 0/1/0/0012",
                     hreadyout, sramcs, sramwen, sramaddr);
        end
        step();
        @(negedge clk);
        vectors++;
        if ({hreadyout, hrdata} !== {1'b1, 32'h55}) begin
            miscompares++;
            $display("FAIL b2b_rdata: got ready=%b rdata=%h expected 1/00000055", hreadyout, hrdata);
        end
        vectors++;
        if ({sramcs, sramwen, sramaddr, sramwdata} !== {1'b1, 4'hF, 14'h11, 32'h2}) begin
            miscompares++;
            $display("FAIL b2b_drain_a: got cs=%b wen=%h addr=%h wdata=%h expected 1/f/0011/00000002",
                     sramcs, sramwen, sramaddr, sramwdata);
        end
        step();
    endtask

    task automatic test_reset_discard();
        sram[32] = 32'h0BADC0DE;
        drive(1'b1, 2'b10, 1'b1, 3'd2, 16'h0080);
        step();
        idle();
        hwdata = 32'hCAFEF00D;
        step();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({sramcs, sramwen} !== 5'b0) begin
            miscompares++;
            $display("FAIL rd_no_write_in_reset: got cs=%b wen=%h expected 0/0", sramcs, sramwen);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({hreadyout, sramcs, sramwen} !== {1'b1, 1'b0, 4'h0}) begin
            miscompares++;
            $display("FAIL rd_after_reset: got ready=%b cs=%b wen=%h expected 1/0/0", hreadyout, sramcs, sramwen);
        end
        drive(1'b1, 2'b10, 1'b0, 3'd2, 16'h0080);
        step();
        idle();
        @(negedge clk);
        vectors++;
        if (hrdata !== 32'h0BADC0DE) begin
            miscompares++;
            $display("FAIL rd_old_data: got %h expected 0badc0de", hrdata);
        end
        step();
        step();
        vectors++;
        if (sram[32] !== 32'h0BADC0DE) begin
            miscompares++;
            $display("FAIL rd_sram_untouched: got %h expected 0badc0de", sram[32]);
        end
    endtask

    task automatic test_unselected_busy();
        drive(1'b1, 2'b10, 1'b1, 3'd2, 16'h0100);
        step();
        hwdata = 32'h600DF00D;
        drive(1'b0, 2'b10, 1'b1, 3'd2, 16'h0104);
        step();
        drive(1'b1, 2'b00, 1'b1, 3'd2, 16'h0104);
        @(negedge clk);
        vectors++;
        if ({sramcs, sramwen, sramaddr} !== {1'b1, 4'hF, 14'h40}) begin
            miscompares++;
            $display("FAIL ub_drain_idle: got cs=%b wen=%h addr=%h expected 1/f/0040", sramcs, sramwen, sramaddr);
        end
        step();
        drive(1'b1, 2'b01, 1'b1, 3'd2, 16'h0104);
        hwdata = 32'hFFFFFFFF;
        step();
        @(negedge clk);
        vectors++;
        if (sramcs !== 1'b0) begin
            miscompares++;
            $display("FAIL ub_busy_write: got cs=%b expected 0", sramcs);
        end
        drive(1'b1, 2'b01, 1'b0, 3'd2, 16'h0104);
        @(negedge clk);
        vectors++;
        if (sramcs !== 1'b0) begin
            miscompares++;
            $display("FAIL ub_busy_read: got cs=%b expected 0", sramcs);
        end
        step();
        idle();
        @(negedge clk);
        vectors++;
        if ({sramcs, hrdata} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL ub_no_data: got cs=%b rdata=%h expected 0/0", sramcs, hrdata);
        end
        step();
        vectors++;
        if ({sram[64], sram[65]} !== {32'h600DF00D, 32'h0}) begin
            miscompares++;
            $display("FAIL ub_sram: got %h %h expected 600df00d 00000000", sram[64], sram[65]);
        end
    endtask

    task automatic test_random();
        logic          pv_v, pv_w, w, cv;
        logic [2:0]    pv_z, z;
        logic [15:0]   pv_a, a;
        logic [31:0]   pv_d, expv;
        logic [3:0]    m;
        int            kind, ws;
        for (int i = 0; i < 8; i++) begin
            sram[256 + i] = 32'h0;
            ref_mem[i]    = 32'h0;
        end
        pv_v = 1'b0; pv_w = 1'b0; pv_z = 3'd0; pv_a = 16'h0; pv_d = 32'h0;
        for (int k = 0; k <= 400; k++) begin
            kind = (k == 400) ? 6 : int'($urandom_range(0, 8));
            a    = 16'h0400 + 16'($urandom_range(0, 31));
            z    = 3'($urandom_range(0, 4));
            w    = 1'($urandom_range(0, 1));
            cv   = 1'b0;
            case (kind)
                6:       drive(1'b1, 2'b00, w, z, a);
                7:       drive(1'b1, 2'b01, w, z, a);
                8:       drive(1'b0, 2'b10, w, z, a);
                default: begin
                    drive(1'b1, kind[0] ? 2'b11 : 2'b10, w, z, a);
                    cv = 1'b1;
                end
            endcase
            hwdata = pv_w ? pv_d : $urandom;
            ws = 0;
            forever begin
                @(negedge clk);
                if (hreadyout === 1'b1) break;
                ws++;
                if (ws > 1) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rnd_stall: more than one wait state at op %0d", k);
                    break;
                end
                step();
            end
            if (pv_v && !pv_w) begin
                expv = ref_mem[pv_a[4:2]];
                vectors++;
                if (hrdata !== expv) begin
                    miscompares++;
                    $display("FAIL rnd_read: op %0d addr %h got %h expected %h", k, pv_a, hrdata, expv);
                end
            end
            step();
            if (pv_v && pv_w) begin
                m = lane_mask(pv_z, pv_a[1:0]);
                for (int l = 0; l < 4; l++)
                    if (m[l]) ref_mem[pv_a[4:2]][8*l +: 8] = pv_d[8*l +: 8];
            end
            pv_v = cv; pv_w = w; pv_z = z; pv_a = a; pv_d = $urandom;
        end
        idle();
        repeat (4) step();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (sram[256 + i] !== ref_mem[i]) begin
                miscompares++;
                $display("FAIL rnd_final_mem: word %0d got %h expected %h", 256 + i, sram[256 + i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] = 32'h0;
        idle();
        hwdata = 32'h0;
        test_reset();
        test_word_write();
        test_merge_hit();
        test_byte_lanes();
        test_back_to_back();
        test_reset_discard();
        test_unselected_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
